// File: rtl/alu_dec_queue.sv
// RV32I ALU-control decode queue: decodes at push, stores {alu_ctrl, use_imm, illegal} per entry.
// Optional macro ALU_DEC_BRANCH_EN enables branch decode (opcode 1100011); otherwise branches are illegal.
module alu_dec_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [4:0]  alu_ctrl_o,
  output logic        use_imm_o,
  output logic        illegal_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [4:0] {
    OP_AND  = 5'b00000,
    OP_OR   = 5'b00001,
    OP_ADD  = 5'b00010,
    OP_SUB  = 5'b00110,
    OP_SLT  = 5'b00111,
    OP_SLL  = 5'b01000,
    OP_SLTU = 5'b01001,
    OP_XOR  = 5'b01010,
    OP_SRL  = 5'b01011,
    OP_SRA  = 5'b01100,
    OP_BNE  = 5'b10001,
    OP_BLT  = 5'b10010,
    OP_BGE  = 5'b10011,
    OP_BLTU = 5'b10100,
    OP_BGEU = 5'b10101,
    OP_BEQ  = 5'b10110
  } alu_op_e;

  logic [6:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  alu_op_e    d_op;
  logic       d_imm, d_ill;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign alt    = instr_i[30];

  always_comb begin
    d_op  = OP_AND;
    d_imm = 1'b0;
    d_ill = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011: begin
        d_imm = (opcode == 7'b0010011);
        case (funct3)
          3'b000: d_op = (alt && !d_imm) ? OP_SUB : OP_ADD;
          3'b001: begin
            if (d_imm && alt) d_ill = 1'b1;
            else              d_op  = OP_SLL;
          end
          3'b010: d_op = OP_SLT;
          3'b011: d_op = OP_SLTU;
          3'b100: d_op = OP_XOR;
          3'b101: d_op = alt ? OP_SRA : OP_SRL;
          3'b110: d_op = OP_OR;
          default: d_op = OP_AND;
        endcase
      end
      7'b0000011, 7'b0100011, 7'b1100111,
      7'b0110111, 7'b0010111, 7'b1101111: begin
        d_op  = OP_ADD;
        d_imm = 1'b1;
      end
`ifdef ALU_DEC_BRANCH_EN
      7'b1100011: begin
        case (funct3)
          3'b000: d_op = OP_BEQ;
          3'b001: d_op = OP_BNE;
          3'b100: d_op = OP_BLT;
          3'b101: d_op = OP_BGE;
          3'b110: d_op = OP_BLTU;
          3'b111: d_op = OP_BGEU;
          default: d_ill = 1'b1;
        endcase
      end
`else
      7'b1100011: d_ill = 1'b1;
`endif
      default: d_ill = 1'b1;
    endcase
    // Illegal entries always carry a clean zero payload.
    if (d_ill) begin
      d_op  = OP_AND;
      d_imm = 1'b0;
    end
  end

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else if (flush_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= {d_op, d_imm, d_ill};
  end

  always_comb begin
    alu_ctrl_o = '0;
    use_imm_o  = 1'b0;
    illegal_o  = 1'b0;
    if (!empty) begin
      {alu_ctrl_o, use_imm_o, illegal_o} = mem[rptr];
    end
  end

endmodule

// File: tb/tb_alu_dec_queue.sv
// Randomized self-checking bench for alu_dec_queue against a queue-based reference model.
// Expectations follow ALU_DEC_BRANCH_EN the same way the design build does.
module tb_alu_dec_queue;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [4:0]  alu_ctrl_o;
  logic        use_imm_o;
  logic        illegal_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [6:0] model_q [$];

  alu_dec_queue #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_ctrl_o  (alu_ctrl_o),
    .use_imm_o   (use_imm_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: table lookup by funct3 and named opcode classes.
  function automatic logic [6:0] ref_decode(input logic [31:0] ins);
    logic [4:0] arith [8];
    logic [4:0] brnch [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic       b30;
    logic [6:0] illegal_entry;
    arith = '{5'b00010, 5'b01000, 5'b00111, 5'b01001, 5'b01010, 5'b01011, 5'b00001, 5'b00000};
    brnch = '{5'b10110, 5'b10001, 5'b00000, 5'b00000, 5'b10010, 5'b10011, 5'b10100, 5'b10101};
    opc = ins[6:0];
    f3  = ins[14:12];
    b30 = ins[30];
    illegal_entry = 7'b0000001;
    if (opc == 7'b0110011) begin
      if (f3 == 3'd0 && b30) return {5'b00110, 2'b00};
      if (f3 == 3'd5 && b30) return {5'b01100, 2'b00};
      return {arith[f3], 2'b00};
    end
    if (opc == 7'b0010011) begin
      if (f3 == 3'd1 && b30) return illegal_entry;
      if (f3 == 3'd5 && b30) return {5'b01100, 2'b10};
      return {arith[f3], 2'b10};
    end
    if (opc inside {7'b0000011, 7'b0100011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111})
      return {5'b00010, 2'b10};
`ifdef ALU_DEC_BRANCH_EN
    if (opc == 7'b1100011) begin
      if (f3 == 3'd2 || f3 == 3'd3) return illegal_entry;
      return {brnch[f3], 2'b00};
    end
`endif
    return illegal_entry;
  endfunction

  task automatic check_model(input string tag);
    logic [6:0] head;
    head = (model_q.size() != 0) ? model_q[0] : 7'd0;
    check({tag, "_out_valid"}, 32'(out_valid_o), 32'(model_q.size() != 0));
    check({tag, "_in_ready"},  32'(in_ready_o),  32'(model_q.size() < DEPTH));
    check({tag, "_alu_ctrl"},  32'(alu_ctrl_o),  32'(head[6:2]));
    check({tag, "_use_imm"},   32'(use_imm_o),   32'(head[1]));
    check({tag, "_illegal"},   32'(illegal_o),   32'(head[0]));
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    logic do_push, do_pop;
    in_valid_i  = v;
    instr_i     = ins;
    out_ready_i = rdy;
    flush_i     = fl;
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = rdy && (model_q.size() != 0);
    @(posedge clk_i);
    if (fl) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(ref_decode(ins));
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [10];
    logic [31:0] w;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100111,
             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0000000};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    logic [6:0]  first_entry;
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; instr_i = '0;
    #12;
    check("reset_in_ready", 32'(in_ready_o), 32'd1);
    check("reset_out_valid", 32'(out_valid_o), 32'd0);
    check("reset_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
    check("reset_flags", 32'({use_imm_o, illegal_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_model("idle");

    // add then sub, consumer always ready
    in_valid_i = 1'b1; instr_i = 32'h002081B3; out_ready_i = 1'b1;
    #1 check("no_bypass_valid", 32'(out_valid_o), 32'd0);
    cycle(1'b1, 32'h002081B3, 1'b1, 1'b0);
    check("add_ctrl", 32'(alu_ctrl_o), 32'h02);
    check("add_valid", 32'(out_valid_o), 32'd1);
    check("add_imm", 32'(use_imm_o), 32'd0);
    cycle(1'b1, 32'h402081B3, 1'b1, 1'b0);
    check("sub_ctrl", 32'(alu_ctrl_o), 32'h06);
    check_model("sub");
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_model("drained1");

    // srai, beq, illegal branch funct3
    cycle(1'b1, 32'h4030D093, 1'b1, 1'b0);
    check("srai_ctrl", 32'(alu_ctrl_o), 32'h0C);
    check("srai_imm", 32'(use_imm_o), 32'd1);
    cycle(1'b1, 32'h00208063, 1'b1, 1'b0);
`ifdef ALU_DEC_BRANCH_EN
    check("beq_ctrl", 32'(alu_ctrl_o), 32'h16);
    check("beq_illegal", 32'(illegal_o), 32'd0);
`else
    check("beq_ctrl", 32'(alu_ctrl_o), 32'h00);
    check("beq_illegal", 32'(illegal_o), 32'd1);
`endif
    cycle(1'b1, 32'h00202063, 1'b1, 1'b0);
    check("br010_ctrl", 32'(alu_ctrl_o), 32'h00);
    check("br010_illegal", 32'(illegal_o), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_model("drained2");

    // fill with consumer stalled; third push refused; head stable
    first_entry = ref_decode(32'h002081B3);
    cycle(1'b1, 32'h002081B3, 1'b0, 1'b0);
    cycle(1'b1, 32'h4030D093, 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready_o), 32'd0);
    cycle(1'b1, 32'h00000033, 1'b0, 1'b0);
    check("full_third_refused", 32'(model_q.size()), 32'd2);
    check("stall_head", 32'({alu_ctrl_o, use_imm_o, illegal_o}), 32'(first_entry));
    check_model("stall");
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_second", 32'(alu_ctrl_o), 32'h0C);
    check_model("drain_a");
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_model("drain_b");

    // flush with two entries and a concurrent push
    cycle(1'b1, 32'h002081B3, 1'b0, 1'b0);
    cycle(1'b1, 32'h402081B3, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000013, 1'b1, 1'b1);
    check("flush_out_valid", 32'(out_valid_o), 32'd0);
    check("flush_in_ready", 32'(in_ready_o), 32'd1);
    check_model("flush");

    // asynchronous reset between edges with one entry held
    cycle(1'b1, 32'h0030F0B3, 1'b0, 1'b0);
    check_model("pre_async");
    #2 rst_i = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid_o), 32'd0);
    check("async_in_ready", 32'(in_ready_o), 32'd1);
    check("async_payload", 32'({alu_ctrl_o, use_imm_o, illegal_o}), 32'd0);
    model_q.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check_model("post_async");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = rand_instr();
      cycle($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
